skew_buf: RTL and testbench

//  Parametrised staggered delay-line bank that skews operand vectors into the

---
 rtl/skew_pkg.sv | 16 +
 rtl/skew_line.sv | 48 ++++
 rtl/skew_buf.sv | 131 +++++++++++++
 tb/tb_skew_buf.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_pkg.sv
// Shared types and helpers for the operand skew buffers.
package skew_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } skew_state_t;

  // Delay of lane x, in shifts.
  function automatic int unsigned lane_depth(int unsigned x, int unsigned base,
                                             int unsigned step);
    return base + x * step;
  endfunction

endpackage

// File: rtl/skew_line.sv
// One skew lane: a Depth-deep data shift register with a valid bit per stage.
module skew_line #(
  parameter int unsigned Bits  = 8,
  parameter int unsigned Depth = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            shift_i,
  input  logic            clr_i,
  input  logic [Bits-1:0] data_i,
  input  logic            vld_i,
  output logic [Bits-1:0] data_o,
  output logic            vld_o
);

  logic [Depth-1:0][Bits-1:0] data_q, data_d;
  logic [Depth-1:0]           vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      data_d = '0;
      vld_d  = '0;
    end else if (shift_i) begin
      data_d[0] = data_i;
      vld_d[0]  = vld_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o = data_q[Depth-1];
  assign vld_o  = vld_q[Depth-1];

endmodule

// File: rtl/skew_buf.sv
// Staggered delay-line bank: lane x delays by Base + x*Step shifts, then drains with zeros.
// Optional beat counter port beat_cnt_o is built when SKEW_PERF_EN is defined.
module skew_buf
  import skew_pkg::*;
#(
  parameter int unsigned Bits  = 8,
  parameter int unsigned Lanes = 8,
  parameter int unsigned Base  = 8,
  parameter int unsigned Step  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic                  in_last_i,
  input  logic [Lanes*Bits-1:0] din_i,
  output logic [Lanes*Bits-1:0] dout_o,
  output logic [Lanes-1:0]      out_vld_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef SKEW_PERF_EN
  ,
  output logic [31:0]           beat_cnt_o
`endif
);

  localparam int unsigned DMax = lane_depth(Lanes - 1, Base, Step);
  localparam int unsigned CntW = $clog2(DMax + 1);

  skew_state_t         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                rdy;
  logic                accept;
  logic                shift;
  logic [Lanes*Bits-1:0] lane_din;

  // In reset the block must not advertise readiness, hence the rst_ni term.
  assign rdy      = rst_ni & (state_q != StDrain);
  assign accept   = in_vld_i & rdy & ~clr_i;
  assign shift    = accept | ((state_q == StDrain) & ~clr_i);
  assign lane_din = accept ? din_i : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clr_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StRun: begin
          if (accept) begin
            if (in_last_i) begin
              state_d = StDrain;
              cnt_d   = CntW'(DMax);
            end else begin
              state_d = StRun;
            end
          end
        end
        StDrain: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar x = 0; x < Lanes; x++) begin : g_lane
    skew_line #(
      .Bits (Bits),
      .Depth(lane_depth(x, Base, Step))
    ) u_line (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .shift_i(shift),
      .clr_i  (clr_i),
      .data_i (lane_din[x*Bits +: Bits]),
      .vld_i  (accept),
      .data_o (dout_o[x*Bits +: Bits]),
      .vld_o  (out_vld_o[x])
    );
  end

  assign in_rdy_o = rdy;
  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;

`ifdef SKEW_PERF_EN
  logic [31:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (accept) begin
      beat_d = beat_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_cnt_o = beat_q;
`endif

endmodule

// File: tb/tb_skew_buf.sv
// Bench for skew_buf (Lanes=4, Base=2, Step=1); covers SKEW_PERF_EN when defined.
module tb_skew_buf;

  localparam int unsigned W    = 8;
  localparam int unsigned L    = 4;
  localparam int unsigned B    = 2;
  localparam int unsigned S    = 1;
  localparam int unsigned DMAX = B + (L - 1) * S;
  localparam int unsigned HN   = 1024;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           clr_i = 1'b0;
  logic           in_vld_i = 1'b0;
  logic           in_last_i = 1'b0;
  logic [L*W-1:0] din_i = '0;
  logic           in_rdy_o;
  logic [L*W-1:0] dout_o;
  logic [L-1:0]   out_vld_o;
  logic           busy_o;
  logic           done_o;
`ifdef SKEW_PERF_EN
  logic [31:0]    beat_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  skew_buf #(
    .Bits (W),
    .Lanes(L),
    .Base (B),
    .Step (S)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .in_vld_i (in_vld_i),
    .in_rdy_o (in_rdy_o),
    .in_last_i(in_last_i),
    .din_i    (din_i),
    .dout_o   (dout_o),
    .out_vld_o(out_vld_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
`ifdef SKEW_PERF_EN
    ,
    .beat_cnt_o(beat_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the tile is a history of shifts; lane x shows the entry made D_x shifts ago.
  logic [L*W-1:0] h_data [HN];
  logic           h_vld  [HN];
  int             m_nshift;
  int             m_phase;   // 0 idle, 1 run, 2 drain
  int             m_left;
  logic           m_done;
  logic [31:0]    m_beats;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_nshift = 0;
      m_phase  = 0;
      m_left   = 0;
      m_done   = 1'b0;
      m_beats  = '0;
    end else begin
      logic acc;
      acc    = in_vld_i && (m_phase != 2) && !clr_i;
      m_done = 1'b0;
      if (clr_i) begin
        m_nshift = 0;
        m_phase  = 0;
        m_left   = 0;
        m_beats  = '0;
      end else begin
        if (acc || m_phase == 2) begin
          h_data[m_nshift % HN] = acc ? din_i : '0;
          h_vld[m_nshift % HN]  = acc;
          m_nshift++;
        end
        if (m_phase == 2) begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 0;
            m_done  = 1'b1;
          end
        end else if (acc) begin
          m_beats++;
          if (in_last_i) begin
            m_phase = 2;
            m_left  = DMAX;
          end else begin
            m_phase = 1;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    logic [L*W-1:0] ed;
    logic [L-1:0]   ev;
    ed = '0;
    ev = '0;
    for (int x = 0; x < L; x++) begin
      int d;
      d = B + x * S;
      if (m_nshift >= d) begin
        ed[x*W +: W] = h_data[(m_nshift - d) % HN][x*W +: W];
        ev[x]        = h_vld[(m_nshift - d) % HN];
      end
    end
    chk("m_dout", 64'(dout_o), 64'(ed));
    chk("m_out_vld", 64'(out_vld_o), 64'(ev));
    chk("m_in_rdy", 64'(in_rdy_o), 64'(rst_ni && m_phase != 2));
    chk("m_busy", 64'(busy_o), 64'(m_phase != 0));
    chk("m_done", 64'(done_o), 64'(m_done));
`ifdef SKEW_PERF_EN
    chk("m_beat_cnt", 64'(beat_cnt_o), 64'(m_beats));
`endif
  end

  function automatic logic [L*W-1:0] pack(input int b);
    logic [L*W-1:0] v;
    for (int x = 0; x < L; x++) v[x*W +: W] = W'(10 * b + x);
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input int b, input logic last);
    in_vld_i  = 1'b1;
    in_last_i = last;
    din_i     = pack(b);
    step();
    in_vld_i  = 1'b0;
    in_last_i = 1'b0;
  endtask

  initial begin
    int rdy_low;
    int dones;

    // 1: reset
    repeat (3) step();
    chk("rst_dout", 64'(dout_o), 64'd0);
    chk("rst_out_vld", 64'(out_vld_o), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_ni = 1'b1;
    step();
    chk("idle_in_rdy", 64'(in_rdy_o), 64'd1);

    // 2: one beat {4,3,2,1} with last
    in_vld_i  = 1'b1;
    in_last_i = 1'b1;
    din_i     = {8'd4, 8'd3, 8'd2, 8'd1};
    step();
    in_vld_i  = 1'b0;
    in_last_i = 1'b0;
    din_i     = '0;
    chk("skew_drain_rdy", 64'(in_rdy_o), 64'd0);
    step();
    chk("skew_vld_l0", 64'(out_vld_o), 64'b0001);
    chk("skew_dat_l0", 64'(dout_o[7:0]), 64'd1);
    step();
    chk("skew_vld_l1", 64'(out_vld_o), 64'b0010);
    chk("skew_dat_l1", 64'(dout_o[15:8]), 64'd2);
    step();
    step();
    chk("skew_vld_l3", 64'(out_vld_o), 64'b1000);
    chk("skew_dat_l3", 64'(dout_o[31:24]), 64'd4);
    step();
    chk("skew_done", 64'(done_o), 64'd1);
    chk("skew_busy_end", 64'(busy_o), 64'd0);
    chk("skew_vld_end", 64'(out_vld_o), 64'd0);
    step();
    chk("skew_done_once", 64'(done_o), 64'd0);

    // 3: stall three cycles mid-tile
    beat(1, 1'b0);
    beat(2, 1'b0);
    beat(3, 1'b0);
    repeat (3) step();
    chk("stall_vld", 64'(out_vld_o), 64'b0011);
    chk("stall_l0", 64'(dout_o[7:0]), 64'd20);
    chk("stall_l1", 64'(dout_o[15:8]), 64'd11);
    beat(4, 1'b0);
    beat(5, 1'b0);
    beat(6, 1'b1);
    repeat (DMAX + 2) step();

    // 4: 8-beat tile, drain length and single done
    for (int b = 1; b <= 8; b++) beat(b + 10, b == 8);
    rdy_low = 0;
    dones   = 0;
    for (int i = 0; i < 20; i++) begin
      if (!in_rdy_o) rdy_low++;
      if (done_o) dones++;
      step();
    end
    chk("drain_rdy_low", 64'(rdy_low), 64'(DMAX));
    chk("drain_done_cnt", 64'(dones), 64'd1);
    chk("drain_vld_end", 64'(out_vld_o), 64'd0);

    // 5: clr mid-run with in_vld high
    beat(1, 1'b0);
    beat(2, 1'b0);
    beat(3, 1'b0);
    clr_i    = 1'b1;
    in_vld_i = 1'b1;
    din_i    = pack(9);
    step();
    clr_i    = 1'b0;
    in_vld_i = 1'b0;
    chk("clr_vld", 64'(out_vld_o), 64'd0);
    chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_done", 64'(done_o), 64'd0);
`ifdef SKEW_PERF_EN
    chk("clr_beat_cnt", 64'(beat_cnt_o), 64'd0);
`endif
    repeat (DMAX + 1) step();
    chk("clr_no_done", 64'(done_o), 64'd0);

    // 6: async reset mid-drain
    beat(7, 1'b1);
    step();
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_dout", 64'(dout_o), 64'd0);
    chk("arst_vld", 64'(out_vld_o), 64'd0);
    chk("arst_rdy", 64'(in_rdy_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    step();
    step();
    chk("arst_no_done", 64'(done_o), 64'd0);
    rst_ni = 1'b1;
    repeat (DMAX + 1) step();
    chk("arst_idle_done", 64'(done_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
